channel_flow_sequencer: RTL and testbench

- Time-shares one serpentine channel chain between N_INLETS solution inlets. The chain is the mixer/serpentine network fed by the inlets.
- For each granted inlet it runs a fixed sequence: prime, dispense (pump for a requested number of cycles), buffer flush, settle.
- Drives the inlet valves, the flush valve and the pump enable.
- Sits between the assay-level scheduler (the requesters) and the valve/pump drivers.

---
 rtl/flow_ctrl_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/channel_flow_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_channel_flow_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flow_ctrl_pkg
//  Description : Shared types and default phase lengths for the channel flow
//                controllers (sequencer state encoding, phase defaults).
//  Revision    : 1.0  initial release
// ============================================================================
package flow_ctrl_pkg;

    // Sequencer phases. The explicit values keep encodings stable when other
    // blocks decode the state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRIME    = 3'd1,
        DISPENSE = 3'd2,
        FLUSH    = 3'd3,
        SETTLE   = 3'd4
    } flow_state_t;

    localparam int PRIME_CYC_DEF  = 8;
    localparam int FLUSH_CYC_DEF  = 16;
    localparam int SETTLE_CYC_DEF = 4;

endpackage : flow_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. The winner is the first set
//                request found searching upward from rr_last+1, wrapping.
//  Ports       : req        - request vector
//                rr_last    - index of the previous winner
//                gnt_onehot - one-hot winner (zero when no request)
//                gnt_idx    - winner index (0 when no request)
//                gnt_valid  - at least one request set
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_last,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    always_comb begin : p_pick
        int cand;
        cand       = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        // Offsets 1..N_REQ visit every index once; offset N_REQ is rr_last
        // itself, so the previous winner has the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(rr_last) + k) % N_REQ;
            if (!gnt_valid && req[cand]) begin
                gnt_valid        = 1'b1;
                gnt_idx          = cand[IDX_W-1:0];
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/channel_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : channel_flow_sequencer
//  Description : Time-shares one serpentine channel chain between N_INLETS
//                inlets. Each granted inlet runs PRIME -> DISPENSE -> FLUSH ->
//                SETTLE, then the chain is released back to arbitration.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                req         - per-inlet level request (drop to abort)
//                req_len     - per-inlet dispense length, CNT_W bits each
//                gnt         - one-hot grant, PRIME through SETTLE
//                valve_open  - inlet valve drive (one-hot or zero)
//                flush_valve - buffer flush valve drive
//                pump_en     - pump enable
//                busy        - not IDLE
//                done        - one-cycle pulse on the last SETTLE cycle
//                done_id     - completing inlet, valid with done
//                aborted     - sequence was cut short, valid with done
//  Revision    : 1.0  initial release
// ============================================================================
module channel_flow_sequencer
    import flow_ctrl_pkg::*;
#(
    parameter int N_INLETS   = 3,
    parameter int CNT_W      = 16,
    parameter int PRIME_CYC  = PRIME_CYC_DEF,
    parameter int FLUSH_CYC  = FLUSH_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_INLETS-1:0]          req,
    input  logic [N_INLETS*CNT_W-1:0]    req_len,
    output logic [N_INLETS-1:0]          gnt,
    output logic [N_INLETS-1:0]          valve_open,
    output logic                         flush_valve,
    output logic                         pump_en,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_INLETS)-1:0]  done_id,
    output logic                         aborted
);

    localparam int IDX_W = $clog2(N_INLETS);
    localparam logic [CNT_W-1:0] C_PRIME_LD  = CNT_W'(PRIME_CYC - 1);
    localparam logic [CNT_W-1:0] C_FLUSH_LD  = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    flow_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_len, w_len_nxt;
    logic [IDX_W-1:0]   r_sel, w_sel_nxt;
    logic [IDX_W-1:0]   r_rr_last, w_rr_last_nxt;
    logic               r_abort, w_abort_nxt;

    logic [N_INLETS-1:0] w_arb_onehot;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_valid;
    logic [N_INLETS-1:0] w_sel_onehot;

    rr_arbiter #(
        .N_REQ (N_INLETS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .rr_last    (r_rr_last),
        .gnt_onehot (w_arb_onehot),
        .gnt_idx    (w_arb_idx),
        .gnt_valid  (w_arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_sel     <= '0;
            r_rr_last <= IDX_W'(N_INLETS - 1);
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_sel     <= w_sel_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    // Next-state logic. Each phase counter is loaded with (length - 1) on
    // entry and the phase ends when it reads zero, so no wrap is needed even
    // for the maximum dispense length.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_sel_nxt     = r_sel;
        w_rr_last_nxt = r_rr_last;
        w_abort_nxt   = r_abort;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt   = PRIME;
                    w_sel_nxt     = w_arb_idx;
                    w_rr_last_nxt = w_arb_idx;
                    w_len_nxt     = req_len[int'(w_arb_idx)*CNT_W +: CNT_W];
                    w_cnt_nxt     = C_PRIME_LD;
                    w_abort_nxt   = 1'b0;
                end
            end
            PRIME: begin
                if (!req[r_sel]) begin
                    // A dropped request still gets a full flush.
                    w_abort_nxt = 1'b1;
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = C_FLUSH_LD;
                end else if (r_cnt == '0) begin
                    if (r_len == '0) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = C_FLUSH_LD;
                    end else begin
                        w_state_nxt = DISPENSE;
                        w_cnt_nxt   = r_len - C_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            DISPENSE: begin
                if (!req[r_sel]) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = C_FLUSH_LD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = C_FLUSH_LD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = C_SETTLE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from registered state only, so the asynchronous reset
    // forces every output low immediately.
    always_comb begin
        w_sel_onehot        = '0;
        w_sel_onehot[r_sel] = 1'b1;
        gnt                 = '0;
        valve_open          = '0;
        flush_valve         = 1'b0;
        pump_en             = 1'b0;
        busy                = (r_state != IDLE);
        done                = 1'b0;
        done_id             = '0;
        aborted             = 1'b0;
        case (r_state)
            PRIME: begin
                gnt        = w_sel_onehot;
                valve_open = w_sel_onehot;
            end
            DISPENSE: begin
                gnt        = w_sel_onehot;
                valve_open = w_sel_onehot;
                pump_en    = 1'b1;
            end
            FLUSH: begin
                gnt         = w_sel_onehot;
                flush_valve = 1'b1;
                pump_en     = 1'b1;
            end
            SETTLE: begin
                gnt = w_sel_onehot;
                if (r_cnt == '0) begin
                    done    = 1'b1;
                    done_id = r_sel;
                    aborted = r_abort;
                end
            end
            default: begin
            end
        endcase
    end

endmodule : channel_flow_sequencer
`default_nettype wire

// File: tb/tb_channel_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_flow_sequencer
//  Description : Self-checking bench for channel_flow_sequencer. Expected
//                sequence records (inlet, abort flag, phase cycle counts) are
//                queued when a request is driven and compared when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_channel_flow_sequencer;

    localparam int N  = 3;
    localparam int CW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*CW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic [N-1:0]    valve_open;
    logic            flush_valve;
    logic            pump_en;
    logic            busy;
    logic            done;
    logic [IW-1:0]   done_id;
    logic            aborted;

    always #5 clk = ~clk;

    channel_flow_sequencer #(
        .N_INLETS   (N),
        .CNT_W      (CW),
        .PRIME_CYC  (8),
        .FLUSH_CYC  (16),
        .SETTLE_CYC (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_len     (req_len),
        .gnt         (gnt),
        .valve_open  (valve_open),
        .flush_valve (flush_valve),
        .pump_en     (pump_en),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .aborted     (aborted)
    );

    // One expected sequence: counts are cycles from grant rise through the
    // done cycle inclusive.
    typedef struct {
        int id;
        int ab;
        int total;
        int valve;
        int pump;
        int flush;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- monitor / scoreboard (samples on falling edge) -------
    int          cyc      = 0;
    logic [N-1:0] prev_gnt = '0;
    bit          in_seq   = 0;
    int          c_tot, c_valve, c_pump, c_flush;
    int          done_cyc = 0;
    int          done_cnt = 0;
    bit          gap_chk  = 0;
    bit          sb_en    = 1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_seq   = 0;
            prev_gnt = '0;
        end else begin
            check("inv_gnt_onehot", int'($onehot0(gnt)), 1);
            check("inv_valve_onehot", int'($onehot0(valve_open)), 1);
            check("inv_valve_flush_excl", int'((valve_open != 0) && flush_valve), 0);
            check("inv_pump_needs_valve",
                  int'(pump_en && (valve_open == 0) && !flush_valve), 0);
            check("inv_busy_vs_gnt", int'(busy), int'(gnt != 0));
            if (prev_gnt == '0 && gnt != '0) begin
                in_seq  = 1;
                c_tot   = 0;
                c_valve = 0;
                c_pump  = 0;
                c_flush = 0;
                if (gap_chk) check("idle_gap_after_done", cyc - done_cyc, 2);
                if (sb_en && sb_q.size() > 0) check("gnt_idx", oh_idx(gnt), sb_q[0].id);
            end
            if (in_seq) begin
                c_tot++;
                if (valve_open != '0) c_valve++;
                if (pump_en)          c_pump++;
                if (flush_valve)      c_flush++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                in_seq   = 0;
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("done_id",      int'(done_id), e.id);
                        check("aborted",      int'(aborted), e.ab);
                        check("seq_cycles",   c_tot,   e.total);
                        check("valve_cycles", c_valve, e.valve);
                        check("pump_cycles",  c_pump,  e.pump);
                        check("flush_cycles", c_flush, e.flush);
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    // ---------------- driver tasks ----------------------------------------
    task automatic set_len(input int i, input int v);
        req_len[i*CW +: CW] = CW'(v);
    endtask

    task automatic push(input int id, input int ab, input int dlen);
        exp_t x;
        x.id    = id;
        x.ab    = ab;
        x.total = 8 + dlen + 16 + 4;
        x.valve = 8 + dlen;
        x.pump  = dlen + 16;
        x.flush = 16;
        sb_q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        req_len = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt < target) check("wait_done_timeout", done_cnt, target);
    endtask

    task automatic wait_high(input string tag, input bit use_pump, input int budget);
        int k;
        k = 0;
        while (!(use_pump ? pump_en : flush_valve) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!(use_pump ? pump_en : flush_valve)) check(tag, 0, 1);
    endtask

    task automatic drop_after_done();
        @(posedge clk);
        #1 req = '0;
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        int tgt;
        rst_n   = 1'b0;
        req     = '0;
        req_len = '0;

        // Reset state
        do_reset();
        check("rst_gnt", int'(gnt), 0);
        check("rst_valve", int'(valve_open), 0);
        check("rst_flush", int'(flush_valve), 0);
        check("rst_pump", int'(pump_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Single request, inlet 1, len 5; grant one cycle after request
        set_len(1, 5);
        req = 3'b010;
        push(1, 0, 5);
        tgt = done_cnt + 1;
        @(posedge clk);
        #1 check("gnt_latency", int'(gnt), 2);
        wait_done(tgt, 100);
        drop_after_done();

        // Round robin, all inlets, len 2: order 0,1,2,0
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 2);
        req = 3'b111;
        push(0, 0, 2);
        push(1, 0, 2);
        push(2, 0, 2);
        push(0, 0, 2);
        tgt = done_cnt + 1;
        wait_done(tgt, 100);
        gap_chk = 1;
        wait_done(tgt + 3, 300);
        drop_after_done();
        gap_chk = 0;

        // Zero length: dispense skipped
        do_reset();
        set_len(0, 0);
        req = 3'b001;
        push(0, 0, 0);
        tgt = done_cnt + 1;
        wait_done(tgt, 100);
        drop_after_done();

        // Abort: inlet 2, len 100, request dropped on dispense cycle 10
        do_reset();
        set_len(2, 100);
        req = 3'b100;
        push(2, 1, 10);
        tgt = done_cnt + 1;
        wait_high("abort_pump_timeout", 1'b1, 50);
        repeat (9) @(posedge clk);
        #1 req = '0;
        wait_done(tgt, 100);

        // Dispense length is latched at grant; later req_len edits ignored
        do_reset();
        set_len(0, 7);
        req = 3'b001;
        push(0, 0, 7);
        tgt = done_cnt + 1;
        wait_high("lenchg_pump_timeout", 1'b1, 50);
        set_len(0, 50);
        wait_done(tgt, 150);
        drop_after_done();

        // Reset during FLUSH of inlet 1; afterwards 3'b110 must grant inlet 1
        do_reset();
        set_len(1, 3);
        set_len(2, 3);
        req = 3'b010;
        wait_high("midrst_flush_timeout", 1'b0, 60);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_valve", int'(valve_open), 0);
        check("midrst_flush", int'(flush_valve), 0);
        check("midrst_pump", int'(pump_en), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        req = 3'b110;
        push(1, 0, 3);
        tgt = done_cnt + 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(tgt, 100);
        drop_after_done();

        // Random traffic: invariants only
        sb_en = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) set_len(i, int'($urandom_range(0, 12)));
        end
        req = '0;
        repeat (60) @(posedge clk);
        sb_en = 1;

        check("sb_leftover", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_channel_flow_sequencer
`default_nettype wire
